// File: rtl/core_config.sv
// Shared configuration for the dcache AXI write path.
//   DCACHELINE_WIDTH : default cache line width in bits
//   AXI_DW           : default AXI data width in bits
//   AXI_BURST_INCR   : AXI INCR burst encoding
//   axi_size()       : AXI AxSIZE encoding for a data width
//   wr_state_e       : write controller FSM states
//   wr_owner_e       : which requester owns the in-flight transaction
package core_config;

  localparam int unsigned DCACHELINE_WIDTH = 128;
  localparam int unsigned AXI_DW           = 32;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [2:0] axi_size(input int unsigned dw);
    return 3'($clog2(dw / 8));
  endfunction

  // With DCACHE_WR_AW_W_PARALLEL_EN defined, StAw acts as the combined AW_W state.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAw   = 2'd1,
    StW    = 2'd2,
    StB    = 2'd3
  } wr_state_e;

  typedef enum logic {
    OwnFifo = 1'b0,
    OwnUc   = 1'b1
  } wr_owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req_i    : request vector, bit 0 = requester 0, bit 1 = requester 1
//   adv_i    : when high and any request is present, the current grant is recorded
//   gnt_o    : one-hot grant (combinational from req_i and the last-grant register)
// After reset requester 0 wins a simultaneous request.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  // High when requester 1 won most recently.
  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    last_d = last_q;
    if (adv_i && (|req_i)) last_d = gnt_o[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/dcache_axi_wr_ctrl.sv
// AXI write-channel controller for the dcache write-back FIFO and the uncached-store path.
// Arbitrates round robin between the two requesters and runs each grant as one AW/W/B
// transaction: a cache line as an INCR burst of BEATS beats, a store as a single beat.
// Completion is signalled only to the owner of the transaction.
//   clk, rst          : clock, asynchronous active-high reset
//   fifo_*            : write-back FIFO request (level), accept pulse, completion pulse
//   uc_*              : uncached store request (level), accept pulse, completion pulse
//   aw*/w*/b*         : AXI write address, data and response channels (bresp_i ignored)
// Build option: DCACHE_WR_AW_W_PARALLEL_EN issues AW and the first W beat together.
module dcache_axi_wr_ctrl #(
  parameter  int unsigned LINE_WIDTH = core_config::DCACHELINE_WIDTH,
  parameter  int unsigned AXI_DW     = core_config::AXI_DW,
  localparam int unsigned BEATS      = LINE_WIDTH / AXI_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_wen_i,
  input  logic [31:0]           fifo_awaddr_i,
  input  logic [LINE_WIDTH-1:0] fifo_wdata_i,
  output logic                  fifo_req_accept_o,
  output logic                  fifo_bvalid_o,
  input  logic                  uc_wreq_i,
  input  logic [31:0]           uc_awaddr_i,
  input  logic [AXI_DW-1:0]     uc_wdata_i,
  input  logic [AXI_DW/8-1:0]   uc_wstrb_i,
  output logic                  uc_accept_o,
  output logic                  uc_done_o,
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [31:0]           awaddr_o,
  output logic [7:0]            awlen_o,
  output logic [2:0]            awsize_o,
  output logic [1:0]            awburst_o,
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [AXI_DW-1:0]     wdata_o,
  output logic [AXI_DW/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [1:0]            bresp_i
);
  import core_config::*;

  localparam int unsigned   SW        = AXI_DW / 8;
  localparam int unsigned   BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  // Clears the byte offset within a line.
  localparam logic [31:0]   LINE_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

  wr_state_e             state_q, state_d;
  wr_owner_e             owner_q, owner_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [BCW-1:0]        beat_q, beat_d;

  logic [1:0] req, gnt;
  logic       in_idle, is_line, last_beat;
  logic       aw_active, w_active, aw_hs, w_hs, b_hs;
  logic       unused_bresp;

  assign unused_bresp = ^bresp_i;

  assign in_idle = (state_q == StIdle);
  assign req     = {uc_wreq_i, fifo_wen_i};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .adv_i (in_idle),
    .gnt_o (gnt)
  );

  assign is_line   = (owner_q == OwnFifo);
  assign last_beat = is_line ? (beat_q == LAST_BEAT) : 1'b1;

`ifdef DCACHE_WR_AW_W_PARALLEL_EN
  // Per-channel completion flags for the combined AW_W state.
  logic aw_done_q, aw_done_d, w0_done_q, w0_done_d;

  assign aw_active = (state_q == StAw) && !aw_done_q;
  assign w_active  = ((state_q == StAw) && !w0_done_q) || (state_q == StW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done_q <= 1'b0;
      w0_done_q <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w0_done_q <= w0_done_d;
    end
  end
`else
  assign aw_active = (state_q == StAw);
  assign w_active  = (state_q == StW);
`endif

  assign aw_hs = aw_active && awready_i;
  assign w_hs  = w_active && wready_i;
  assign b_hs  = (state_q == StB) && bvalid_i;

  // Payload is forced to zero whenever its channel is not valid.
  assign awvalid_o = aw_active;
  assign awaddr_o  = aw_active ? (is_line ? (addr_q & LINE_MASK) : addr_q) : 32'd0;
  assign awlen_o   = (aw_active && is_line) ? 8'(BEATS - 1) : 8'd0;
  assign awsize_o  = axi_size(AXI_DW);
  assign awburst_o = AXI_BURST_INCR;

  assign wvalid_o = w_active;
  assign wdata_o  = w_active ? data_q[32'(beat_q) * AXI_DW +: AXI_DW] : '0;
  assign wstrb_o  = w_active ? (is_line ? {SW{1'b1}} : strb_q) : '0;
  assign wlast_o  = w_active && last_beat;

  assign bready_o = (state_q == StB);

  assign fifo_req_accept_o = in_idle && gnt[0];
  assign uc_accept_o       = in_idle && gnt[1];
  assign fifo_bvalid_o     = b_hs && (owner_q == OwnFifo);
  assign uc_done_o         = b_hs && (owner_q == OwnUc);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    beat_d  = beat_q;
`ifdef DCACHE_WR_AW_W_PARALLEL_EN
    aw_done_d = aw_done_q;
    w0_done_d = w0_done_q;
`endif
    if (w_hs) beat_d = last_beat ? '0 : beat_q + BCW'(1);

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          beat_d  = '0;
          state_d = StAw;
          if (gnt[0]) begin
            owner_d = OwnFifo;
            addr_d  = fifo_awaddr_i;
            data_d  = fifo_wdata_i;
            strb_d  = {SW{1'b1}};
          end else begin
            owner_d = OwnUc;
            addr_d  = uc_awaddr_i;
            data_d  = LINE_WIDTH'(uc_wdata_i);
            strb_d  = uc_wstrb_i;
          end
`ifdef DCACHE_WR_AW_W_PARALLEL_EN
          aw_done_d = 1'b0;
          w0_done_d = 1'b0;
`endif
        end
      end
      StAw: begin
`ifdef DCACHE_WR_AW_W_PARALLEL_EN
        aw_done_d = aw_done_q || aw_hs;
        w0_done_d = w0_done_q || w_hs;
        if (aw_done_d && w0_done_d) begin
          state_d   = (is_line && (BEATS > 1)) ? StW : StB;
          aw_done_d = 1'b0;
          w0_done_d = 1'b0;
        end
`else
        if (aw_hs) state_d = StW;
`endif
      end
      StW: begin
        if (w_hs && last_beat) state_d = StB;
      end
      StB: begin
        if (b_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnFifo;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: doc/dcache_axi_wr_ctrl.md
# dcache_axi_wr_ctrl

Write-channel controller that sits between the dcache write-back FIFO and the uncached-store path on one side and the single AXI write master port on the other. It arbitrates between the two requesters and sequences each granted request as an AXI AW / W / B transaction. A cache line goes out as an INCR burst; an uncached store goes out as a single beat. Completion is returned only to the requester that owns the transaction, so the FIFO pops only on its own write response.

## Interface
Parameters:
- LINE_WIDTH, default DCACHELINE_WIDTH: bits per cache line; must be a multiple of AXI_DW.
- AXI_DW, default 32: AXI data width.
- BEATS, default LINE_WIDTH/AXI_DW: beats per line burst; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_wen_i  in  1  FIFO has a head line to write; level signal.
- fifo_awaddr_i  in  32  line address.
- fifo_wdata_i  in  LINE_WIDTH  line data.
- fifo_req_accept_o  out  1  one-cycle pulse: FIFO request granted.
- fifo_bvalid_o  out  1  one-cycle pulse: FIFO transaction complete.
- uc_wreq_i  in  1  uncached store request; level signal.
- uc_awaddr_i  in  32  store address.
- uc_wdata_i  in  AXI_DW  store data.
- uc_wstrb_i  in  AXI_DW/8  store byte strobes.
- uc_accept_o  out  1  one-cycle pulse: store granted.
- uc_done_o  out  1  one-cycle pulse: store complete.
- AW channel: awvalid_o out 1, awready_i in 1, awaddr_o out 32, awlen_o out 8, awsize_o out 3, awburst_o out 2.
- W channel: wvalid_o out 1, wready_i in 1, wdata_o out AXI_DW, wstrb_o out AXI_DW/8, wlast_o out 1.
- B channel: bvalid_i in 1, bready_o out 1, bresp_i in 2 (ignored).

## Operation
- FSM states: IDLE, AW, W, B. Reset state is IDLE.
- **IDLE:** if any request is pending, grant one requester, pulse its accept output, latch address, data, strobes and owner, then go to AW.
- **Arbitration:** two-way round robin.
  - When both request, grant the one not granted last.
  - After reset, the last-grant pointer favours the FIFO.
  - A single request is granted immediately.
- **AW:** awvalid_o=1.
  - Line: awaddr_o = latched address with the low log2(LINE_WIDTH/8) bits forced to 0; awlen_o=BEATS-1.
  - Store: awaddr_o = latched address as given; awlen_o=0.
  - Always awsize_o=log2(AXI_DW/8) and awburst_o=2'b01 (INCR).
  - On awvalid_o & awready_i, go to W.
- **W:** wvalid_o=1.
  - Line: beat k drives wdata_o = line[AXI_DW*k +: AXI_DW] and wstrb_o = all ones.
  - Store: wdata_o = uc_wdata_i and wstrb_o = uc_wstrb_i, as latched.
  - The beat counter increments on each wvalid_o & wready_i.
  - wlast_o=1 on the final beat (beat BEATS-1 for a line, beat 0 for a store).
  - The handshake on the last beat moves to B.
- **B:** bready_o=1. On bvalid_i & bready_o, pulse the owner's done output (fifo_bvalid_o or uc_done_o) in that same cycle, then go to IDLE.
- **Reset values:** every valid, ready, accept and done output is 0; awlen_o, awaddr_o, wdata_o, wstrb_o and wlast_o are 0; the beat counter is 0.
- Requests arriving while not in IDLE wait; no accept pulse is issued outside IDLE.
- Reset asserted mid-transaction returns the FSM to IDLE immediately and drops all valids. The AXI slave and the FIFO share rst.
- Only one transaction is outstanding at a time; no write interleaving.

## Timing
- A request visible in cycle t (IDLE) produces its accept pulse in cycle t. awvalid_o rises in t+1.
- With awready and wready tied high: a store has its W beat at t+2 and bready at t+3. A line has W beats t+2 .. t+1+BEATS.
- The done pulse coincides with the B handshake. The earliest next grant is in the cycle after the done pulse.
- Stalls on awready_i, wready_i or bvalid_i hold all payload outputs stable.

## Configuration
- `DCACHE_WR_AW_W_PARALLEL_EN`
  - **Defined:** the AW state is replaced by AW_W. awvalid_o and the first-beat wvalid_o rise together. Each channel drops independently on its own handshake. The FSM leaves AW_W once both AW and the first beat have completed, going to W if beats remain, else to B. Best-case latency drops by one cycle.
  - **Undefined:** W is issued strictly after the AW handshake, as in Operation.

## Structure
- core_config package holds:
  - AXI_DW
  - burst and size constants (INCR, size encoding)
  - the FSM state enum
  - the owner enum (FIFO / UC)
- Sub-module rr_arbiter2: a two-requester round-robin arbiter with its own last-grant register and an advance enable.
- Everything else is in dcache_axi_wr_ctrl.

## Test plan
- Single store, addr 0x1000_0004, data 0xDEADBEEF, strb 4'b0011, all readies high -> uc_accept_o in t, AW at t+1 with awlen 0, one W beat with wlast_o=1 and the given data/strb, uc_done_o on the B handshake, fifo_bvalid_o never asserted.
- FIFO line at 0x0000_2018 with LINE_WIDTH=128 -> awaddr_o 0x0000_2010, awlen_o 3, four beats in ascending word order, wlast_o only on beat 3, fifo_bvalid_o one pulse.
- FIFO and store requesting continuously from reset -> grants alternate FIFO, UC, FIFO, UC; the accept pulses never overlap.
- Random awready_i / wready_i / bvalid_i stalls of 0-5 cycles -> payload stable during each stall, beat count exact, one done pulse per transaction.
- Reset asserted during the W state of a line (beat 2 of 4) -> all valids 0 in the same cycle; a fresh request after reset gets a full burst starting at beat 0.
- With the macro defined: store with readies high -> awvalid_o and wvalid_o both asserted in t+1, bready_o in t+2.
